// File: rtl/bus_defs_pkg.sv
// Shared definitions for the bus arbiter and its round-robin priority picker.
// Holds the arbiter state encodings, the default bus word width and a helper
// that sizes source-index fields from the number of requesters.
package bus_defs;

   localparam int DEFAULT_DATA_W  = 32;
   localparam int DEFAULT_NUM_SRC = 4;

   // Arbiter states, encoded so the bench and any later bus master agree:
   //   IDLE    | no owner, pick a winner when any request is present
   //   SETUP   | winner's word is on bus_data, enable still low
   //   DRIVE   | bus_en high, bus_data tracks the winner's word
   //   RELEASE | turnaround cycle, enable low, pointer advances
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SETUP   = 2'b01,
      DRIVE   = 2'b10,
      RELEASE = 2'b11
   } arb_state_e;

   // Width of an index that selects one of n sources (never less than 1 bit).
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority.sv
// Round-robin priority picker.
// Purely combinational: finds the first set request bit starting at rr_ptr
// and searching upward, wrapping modulo NUM_SRC. Kept separate so other bus
// masters can reuse the same fairness rule.
module rr_priority
   import bus_defs::*;
#(
   parameter int NUM_SRC = DEFAULT_NUM_SRC,
   parameter int IDX_W   = idx_w(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   // One extra bit so rr_ptr + offset cannot overflow before the wrap.
   logic [IDX_W:0]   cand_sum;
   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest set bit wins last.
   always_comb begin
      winner   = '0;
      cand_sum = '0;
      cand     = '0;
      for (int off = NUM_SRC - 1; off >= 0; off--) begin
         cand_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
         if (cand_sum >= (IDX_W + 1)'(NUM_SRC)) begin
            cand_sum = cand_sum - (IDX_W + 1)'(NUM_SRC);
         end
         cand = cand_sum[IDX_W-1:0];
         if (req[cand]) begin
            winner = cand;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter feeding the 32-bit tri-state bus buffers.
// Registers the winning source's word onto bus_data and drives bus_en with a
// setup cycle before and a turnaround cycle after every drive window, so two
// buffer drivers can never overlap.
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to limit each grant to MAX_HOLD
// cycles of bus_en; the owner is then revoked and timeout pulses once.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; pick round-robin winner, load grant and bus_data
//   SETUP   | data stable on the buffer input, enable raised on exit
//   DRIVE   | buffer enabled, bus_data follows winner until done/req drop
//   RELEASE | bus turnaround, enable low, rr_ptr moves past the winner
module bus_arbiter
   import bus_defs::*;
#(
   parameter int NUM_SRC  = DEFAULT_NUM_SRC,
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int MAX_HOLD = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        req,
   input  logic [NUM_SRC-1:0]        done,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        grant,
   output logic [DATA_W-1:0]         bus_data,
   output logic                      bus_en,
   output logic                      busy,
   output logic                      timeout
);

   localparam int IDX_W = idx_w(NUM_SRC);

   if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
      $error("bus_arbiter: NUM_SRC must be in 2..8");
   end
   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("bus_arbiter: MAX_HOLD must be at least 1");
   end

   arb_state_e           state_q,    state_d;
   logic [NUM_SRC-1:0]   grant_q,    grant_d;
   logic [DATA_W-1:0]    bus_data_q, bus_data_d;
   logic                 bus_en_q,   bus_en_d;
   logic                 busy_q,     busy_d;
   logic                 timeout_q,  timeout_d;
   logic [IDX_W-1:0]     winner_q,   winner_d;
   logic [IDX_W-1:0]     rr_ptr_q,   rr_ptr_d;

   logic [IDX_W-1:0]     rr_winner;
   logic                 rr_any;
   logic                 owner_exit;

   // Unpacked view of the packed source words, indexed by source number.
   logic [DATA_W-1:0]    src_word [NUM_SRC];

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_word
      assign src_word[g] = src_data[g*DATA_W +: DATA_W];
   end

   rr_priority #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_priority (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .winner  (rr_winner),
      .any_req (rr_any)
   );

   // Only the stored winner's done/req bits can end a transfer; the others
   // are deliberately not looked at while the bus is owned.
   assign owner_exit = done[winner_q] | ~req[winner_q];

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic                 hold_limit;

   assign hold_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

   // Hold counter register: counts DRIVE cycles of the current grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`endif

   // Next-state and next-output decode for the arbitration sequence.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      bus_data_d = bus_data_q;
      bus_en_d   = bus_en_q;
      winner_d   = winner_q;
      rr_ptr_d   = rr_ptr_q;
      timeout_d  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (rr_any) begin
               winner_d   = rr_winner;
               grant_d    = NUM_SRC'(1) << rr_winner;
               bus_data_d = src_word[rr_winner];
               state_d    = SETUP;
            end
         end

         SETUP: begin
            bus_en_d = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
            state_d  = DRIVE;
         end

         DRIVE: begin
            if (owner_exit) begin
               bus_en_d = 1'b0;
               grant_d  = '0;
               state_d  = RELEASE;
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (hold_limit) begin
               bus_en_d  = 1'b0;
               grant_d   = '0;
               timeout_d = 1'b1;
               state_d   = RELEASE;
`endif
            end else begin
               bus_data_d = src_word[winner_q];
`ifdef BUS_ARB_TIMEOUT_EN
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
            end
         end

         RELEASE: begin
            rr_ptr_d = (winner_q == IDX_W'(NUM_SRC - 1)) ? '0 : winner_q + IDX_W'(1);
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset clears the bus immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         bus_data_q <= '0;
         bus_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         winner_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         bus_data_q <= bus_data_d;
         bus_en_q   <= bus_en_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         winner_q   <= winner_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign grant    = grant_q;
   assign bus_data = bus_data_q;
   assign bus_en   = bus_en_q;
   assign busy     = busy_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. A transaction-level model (owner,
// turnaround flag, round-robin pointer) predicts grant, bus_en, bus_data,
// busy and timeout; directed scenarios add fixed expectations.
module tb_bus_arbiter;

   localparam int N        = 4;
   localparam int DW       = 32;
   localparam int MAX_HOLD = 15;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N-1:0]      done = '0;
   logic [N*DW-1:0]   src_data = '0;
   logic [N-1:0]      grant;
   logic [DW-1:0]     bus_data;
   logic              bus_en;
   logic              busy;
   logic              timeout;

   int tests_run = 0;
   int tests_failed = 0;

   bus_arbiter #(
      .NUM_SRC  (N),
      .DATA_W   (DW),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .done     (done),
      .src_data (src_data),
      .grant    (grant),
      .bus_data (bus_data),
      .bus_en   (bus_en),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int            m_owner;   // -1 when nobody owns the bus
   logic          m_en;
   logic          m_cool;    // bus turnaround cycle after a release
   logic          m_to;
   logic [DW-1:0] m_data;
   int            m_ptr;
   int            m_hold;

   function automatic void model_reset();
      m_owner = -1; m_en = 0; m_cool = 0; m_to = 0; m_data = '0; m_ptr = 0; m_hold = 0;
   endfunction

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [DW-1:0] word_of(input int i);
      return src_data[i*DW +: DW];
   endfunction

   // Advance the model by one clock using the inputs present at the edge.
   function automatic void model_step();
      int  w;
      bit  stop;
      m_to = 0;
      if (m_cool) begin
         m_cool = 0;
      end else if (m_owner < 0) begin
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_data  = word_of(w);
         end
      end else if (!m_en) begin
         m_en   = 1;
         m_hold = 0;
      end else begin
         stop = done[m_owner] || !req[m_owner];
`ifdef BUS_ARB_TIMEOUT_EN
         if (!stop && m_hold == MAX_HOLD - 1) begin
            stop = 1;
            m_to = 1;
         end
`endif
         if (stop) begin
            m_en    = 0;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cool  = 1;
         end else begin
            m_data = word_of(m_owner);
            m_hold++;
         end
      end
   endfunction

   function automatic logic [N-1:0] exp_grant();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic logic exp_busy();
      return (m_owner >= 0) || m_cool;
   endfunction

   // One clock: model follows the edge, outputs are then sampled at negedge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      done  = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      tests_run++; if (grant !== '0)    begin tests_failed++; $display("FAIL reset_grant got %b want 0", grant); end
      tests_run++; if (bus_en !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_en got %b want 0", bus_en); end
      tests_run++; if (bus_data !== '0) begin tests_failed++; $display("FAIL reset_bus_data got %h want 0", bus_data); end
      tests_run++; if (busy !== 1'b0)   begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got %b want 0", timeout); end
      reset = 1'b0;
      tick();
      tests_run++; if (busy !== 1'b0 || grant !== '0) begin tests_failed++; $display("FAIL idle_no_req busy %b grant %b want 0 0", busy, grant); end
   endtask

   task automatic test_single();
      reset_dut();
      src_data[1*DW +: DW] = 32'h0000_0100;
      req = 4'b0010;                       // cycle 0
      tick();                              // cycle 1
      tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL single_grant_c1 got %b want 0010", grant); end
      tests_run++; if (bus_en !== 1'b0)   begin tests_failed++; $display("FAIL single_en_c1 got %b want 0", bus_en); end
      tests_run++; if (bus_data !== 32'h0000_0100) begin tests_failed++; $display("FAIL single_data_c1 got %h want 00000100", bus_data); end
      for (int c = 2; c <= 6; c++) begin
         tick();
         tests_run++; if (bus_en !== 1'b1 || bus_data !== 32'h0000_0100) begin tests_failed++; $display("FAIL single_drive_c%0d en %b data %h want 1 00000100", c, bus_en, bus_data); end
      end
      done = 4'b0010;                      // done during cycle 6
      tick();                              // cycle 7
      done = '0;
      req  = '0;
      tests_run++; if (bus_en !== 1'b0 || grant !== '0) begin tests_failed++; $display("FAIL single_release_c7 en %b grant %b want 0 0000", bus_en, grant); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_c7 got %b want 1", busy); end
      tick();
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle_c8 busy got %b want 0", busy); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_seq [5];
      logic [N-1:0] seen [$];
      logic [N-1:0] prev_grant;
      logic         prev_en;
      bit           seen_high;
      int           low_run;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset_dut();
      for (int i = 0; i < N; i++) src_data[i*DW +: DW] = 32'hA000_0000 + i;
      req = '1;
      prev_grant = '0; prev_en = 0; seen_high = 0; low_run = 0;
      for (int c = 0; c < 80 && seen.size() < 5; c++) begin
         done = '0;
         if (m_owner >= 0 && m_en && m_hold == 1) done[m_owner] = 1'b1;
         tick();
         tests_run++; if (grant !== exp_grant() || bus_en !== m_en) begin tests_failed++; $display("FAIL rr_lockstep grant %b en %b want %b %b", grant, bus_en, exp_grant(), m_en); end
         if (grant !== '0 && prev_grant === '0) seen.push_back(grant);
         if (bus_en && !prev_en && seen_high) begin
            tests_run++; if (low_run < 2) begin tests_failed++; $display("FAIL rr_gap low cycles %0d want >=2", low_run); end
         end
         if (bus_en) begin seen_high = 1; low_run = 0; end else low_run++;
         prev_grant = grant;
         prev_en    = bus_en;
      end
      done = '0;
      req  = '0;
      tests_run++; if (seen.size() != 5) begin tests_failed++; $display("FAIL rr_count grants seen %0d want 5", seen.size()); end
      for (int i = 0; i < seen.size() && i < 5; i++) begin
         tests_run++; if (seen[i] !== exp_seq[i]) begin tests_failed++; $display("FAIL rr_order[%0d] got %b want %b", i, seen[i], exp_seq[i]); end
      end
   endtask

   task automatic test_data_tracking();
      reset_dut();
      for (int i = 0; i < N; i++) src_data[i*DW +: DW] = $urandom();
      req = 4'b0100;
      tick();
      tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL track_grant got %b want 0100", grant); end
      tick();
      for (int k = 0; k < 32; k++) begin
         src_data[2*DW +: DW] = 32'h1 << k;
         src_data[1*DW +: DW] = $urandom();
         tick();
         tests_run++; if (bus_data !== (32'h1 << k) || bus_en !== 1'b1) begin tests_failed++; $display("FAIL track_k%0d data %h en %b want %h 1", k, bus_data, bus_en, 32'h1 << k); end
      end
      req = '0;
      src_data[2*DW +: DW] = 32'h1234_5678;
      tick();
      tests_run++; if (bus_en !== 1'b0 || bus_data !== 32'h8000_0000) begin tests_failed++; $display("FAIL track_exit en %b data %h want 0 80000000", bus_en, bus_data); end
   endtask

   task automatic test_req_drop_ignored_done();
      reset_dut();
      req = 4'b0001;
      tick();
      tick();
      done = 4'b1110;
      req  = 4'b1001;
      tick();
      tests_run++; if (bus_en !== 1'b1 || grant !== 4'b0001) begin tests_failed++; $display("FAIL ignored_done en %b grant %b want 1 0001", bus_en, grant); end
      done = '0;
      req  = 4'b0000;
      tick();
      tests_run++; if (bus_en !== 1'b0 || grant !== '0 || busy !== 1'b1) begin tests_failed++; $display("FAIL req_drop en %b grant %b busy %b want 0 0000 1", bus_en, grant, busy); end
      req = 4'b0100;                       // raised during RELEASE
      tick();
      tests_run++; if (grant !== '0 || busy !== 1'b0) begin tests_failed++; $display("FAIL release_raise_idle grant %b busy %b want 0000 0", grant, busy); end
      tick();
      tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL release_raise_grant got %b want 0100", grant); end
      tick();
      done = 4'b0100;
      req  = 4'b0000;                      // done and drop together
      tick();
      done = '0;
      tests_run++; if (bus_en !== 1'b0 || grant !== '0 || busy !== 1'b1) begin tests_failed++; $display("FAIL both_exit en %b grant %b busy %b want 0 0000 1", bus_en, grant, busy); end
      for (int c = 0; c < 3; c++) begin
         tick();
         tests_run++; if (busy !== 1'b0 || bus_en !== 1'b0) begin tests_failed++; $display("FAIL single_release busy %b en %b want 0 0", busy, bus_en); end
      end
   endtask

   task automatic test_reset_mid_drive();
      reset_dut();
      src_data[1*DW +: DW] = 32'hDEAD_BEEF;
      req = 4'b0010;
      tick();
      tick();
      tests_run++; if (bus_en !== 1'b1 || bus_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL mid_pre en %b data %h want 1 deadbeef", bus_en, bus_data); end
      reset = 1'b1;
      #1;
      tests_run++; if (grant !== '0 || bus_en !== 1'b0) begin tests_failed++; $display("FAIL async_reset grant %b en %b want 0000 0", grant, bus_en); end
      tests_run++; if (bus_data !== 32'h0 || busy !== 1'b0) begin tests_failed++; $display("FAIL async_reset data %h busy %b want 0 0", bus_data, busy); end
      #1;
      reset = 1'b0;
      model_reset();
      tick();
      tests_run++; if (grant !== exp_grant() || grant !== 4'b0010) begin tests_failed++; $display("FAIL after_reset_grant got %b want 0010", grant); end
      req = '0;
   endtask

`ifdef BUS_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int           first_high;
      int           pulses;
      bit           first_done;
      bit           got_second;
      logic [N-1:0] second;
      logic         prev_en;
      reset_dut();
      req = 4'b0011;
      first_high = 0; pulses = 0; first_done = 0; got_second = 0; second = '0; prev_en = 0;
      for (int c = 0; c < 80 && !got_second; c++) begin
         tick();
         tests_run++; if (grant !== exp_grant() || bus_en !== m_en || timeout !== m_to) begin tests_failed++; $display("FAIL to_lockstep grant %b en %b to %b want %b %b %b", grant, bus_en, timeout, exp_grant(), m_en, m_to); end
         if (bus_en && !first_done) first_high++;
         if (!bus_en && prev_en) first_done = 1;
         if (timeout) pulses++;
         if (first_done && grant !== '0) begin got_second = 1; second = grant; end
         prev_en = bus_en;
      end
      req = '0;
      tests_run++; if (first_high != MAX_HOLD) begin tests_failed++; $display("FAIL to_high_cycles got %0d want %0d", first_high, MAX_HOLD); end
      tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL to_pulses got %0d want 1", pulses); end
      tests_run++; if (second !== 4'b0010) begin tests_failed++; $display("FAIL to_next_grant got %b want 0010", second); end
   endtask
`else
   task automatic test_no_timeout();
      reset_dut();
      req = 4'b1000;
      tick();
      tick();
      for (int c = 0; c < 40; c++) begin
         tick();
         tests_run++; if (bus_en !== 1'b1 || timeout !== 1'b0 || grant !== 4'b1000) begin tests_failed++; $display("FAIL no_timeout c%0d en %b to %b grant %b want 1 0 1000", c, bus_en, timeout, grant); end
      end
      req = '0;
   endtask
`endif

   task automatic test_random();
      reset_dut();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i]) req[i] = ($urandom_range(3) == 0);
            else if ($urandom_range(15) == 0) req[i] = 1'b0;
            done[i] = ($urandom_range(7) == 0);
            src_data[i*DW +: DW] = $urandom();
         end
         tick();
         tests_run++;
         if (grant !== exp_grant() || bus_en !== m_en || bus_data !== m_data || busy !== exp_busy() || timeout !== m_to) begin
            tests_failed++;
            $display("FAIL rand_c%0d grant %b en %b data %h busy %b to %b want %b %b %h %b %b",
                     c, grant, bus_en, bus_data, busy, timeout, exp_grant(), m_en, m_data, exp_busy(), m_to);
         end
      end
      req  = '0;
      done = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_data_tracking();
      test_req_drop_ignored_done();
      test_reset_mid_drive();
`ifdef BUS_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
